// File: rtl/instruction_dump.sv
// instruction_dump: reads back flashed instruction memory and streams it one byte per valid/ready handshake.
module instruction_dump #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   dumpCount,
  output logic                  rdEn,
  output logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic [7:0]            rdData,
  output logic                  dumpValid,
  output logic [7:0]            dumpInstruction,
  input  logic                  dumpReady,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, FINISH} state_t;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, last_addr;
  logic [ADDR_WIDTH:0] len;
  logic hs, last;
  assign hs = dumpValid & dumpReady;
  assign last = {1'b0, addr} == len - 1'b1;
  assign rdEn = state == ISSUE;
  // rdAddr must hold its previous value between reads, not follow addr.
  assign rdAddr = rdEn ? addr : last_addr;
  assign dumpValid = state == SEND;
  assign busy = state == ISSUE || state == CAPTURE || state == SEND;
  assign done = state == FINISH;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (dumpCount == '0 ? FINISH : ISSUE) : IDLE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = SEND;
      SEND:    state_nx = hs ? (last ? FINISH : ISSUE) : SEND;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      last_addr <= '0;
      len <= '0;
      dumpInstruction <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        len <= dumpCount > MAX_LEN ? MAX_LEN : dumpCount;
        addr <= '0;
      end
      if (state == ISSUE) last_addr <= addr;
      if (state == CAPTURE) dumpInstruction <= rdData;
      if (state == SEND && hs && !last) addr <= addr + 1'b1;
    end
  end
endmodule

// File: tb/tb_instruction_dump.sv
// tb_instruction_dump: directed vectors against hand-derived cycle timelines.
module tb_instruction_dump;
  logic clk = 1'b0;
  logic reset, start, rdEn, dumpValid, dumpReady, busy, done;
  logic [8:0] dumpCount;
  logic [7:0] rdAddr, rdData, dumpInstruction;
  logic [7:0] mem [256];
  int vectors = 0;
  int miscompares = 0;

  instruction_dump #(.ADDR_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dumpCount(dumpCount),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData), .dumpValid(dumpValid),
    .dumpInstruction(dumpInstruction), .dumpReady(dumpReady), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rdEn) rdData <= mem[rdAddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " rdEn"}, 32'(rdEn), 0);
    chk({tag, " dumpValid"}, 32'(dumpValid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  // Returns at the negedge of cycle 1 (start sampled at edge 0).
  task automatic pulse_start(input int count);
    @(negedge clk);
    start = 1'b1;
    dumpCount = 9'(count);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Unstalled dump of n bytes: rdEn at 3k+1, dumpValid at 3k+3, done at 3n+1.
  task automatic run_full(input string name, input int count, input int n, input int restart);
    pulse_start(count);
    for (int c = 1; c <= 3 * n + 4; c++) begin
      start = (c == restart);
      dumpCount = (c == restart) ? 9'd5 : dumpCount;
      chk($sformatf("%s c%0d rdEn", name, c), 32'(rdEn), 32'(c % 3 == 1 && c <= 3 * n - 2));
      chk($sformatf("%s c%0d dumpValid", name, c), 32'(dumpValid), 32'(c % 3 == 0 && c <= 3 * n));
      chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c <= 3 * n));
      chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == 3 * n + 1));
      if (c % 3 == 1 && c <= 3 * n - 2)
        chk($sformatf("%s c%0d rdAddr", name, c), 32'(rdAddr), 32'((c - 1) / 3));
      if (c % 3 == 0 && c <= 3 * n)
        chk($sformatf("%s c%0d byte", name, c), 32'(dumpInstruction), 32'(8'(8'hA0 + c / 3 - 1)));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'hA0 + i);
    reset = 1'b1;
    start = 1'b0;
    dumpCount = '0;
    dumpReady = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset rdAddr", 32'(rdAddr), 0);
    chk("reset byte", 32'(dumpInstruction), 0);
    reset = 1'b0;

    run_full("full", 4, 4, 0);
    run_full("zero", 0, 0, 0);
    run_full("clamp", 20, 16, 0);
    run_full("busy_start", 3, 3, 2);

    pulse_start(4);
    for (int c = 1; c <= 19; c++) begin
      automatic logic v = c == 3 || c == 14 || c == 17 || (c >= 6 && c <= 11);
      automatic logic [7:0] b = c == 3 ? 8'hA0 : c <= 11 ? 8'hA1 : c == 14 ? 8'hA2 : 8'hA3;
      dumpReady = !(c >= 6 && c <= 10);
      chk($sformatf("bp c%0d rdEn", c), 32'(rdEn), 32'(c == 1 || c == 4 || c == 12 || c == 15));
      chk($sformatf("bp c%0d dumpValid", c), 32'(dumpValid), 32'(v));
      chk($sformatf("bp c%0d busy", c), 32'(busy), 32'(c <= 17));
      chk($sformatf("bp c%0d done", c), 32'(done), 32'(c == 18));
      if (v) chk($sformatf("bp c%0d byte", c), 32'(dumpInstruction), 32'(b));
      @(negedge clk);
    end
    dumpReady = 1'b1;

    pulse_start(4);
    repeat (8) @(negedge clk);
    chk("mid valid", 32'(dumpValid), 1);
    chk("mid byte", 32'(dumpInstruction), 32'(8'hA2));
    reset = 1'b1;
    start = 1'b1;
    dumpCount = 9'd4;
    @(negedge clk);
    chk_idle("mid reset");
    chk("mid reset rdAddr", 32'(rdAddr), 0);
    chk("mid reset byte", 32'(dumpInstruction), 0);
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_idle($sformatf("post reset %0d", c));
    end
    run_full("recover", 2, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
